// File: rtl/bcd_digit_accumulator_if.sv
// Operand-entry bus for the BCD digit accumulator.
// The operator side drives the digit, the add request and clear.
// The accumulator side returns the running sum and status.
interface bcd_digit_accumulator_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       D;
  logic             Go;
  logic             Clr;
  logic [3:0]       Tens;
  logic [3:0]       Ones;
  logic             Ovf;
  logic             Err;
  logic [CNT_W-1:0] Cnt;
  logic             Busy;

  modport master (
    output D, Go, Clr,
    input  Tens, Ones, Ovf, Err, Cnt, Busy
  );

  modport slave (
    input  D, Go, Clr,
    output Tens, Ones, Ovf, Err, Cnt, Busy
  );
endinterface

// File: rtl/bcd_digit_accumulator.sv
// Two-digit BCD running-sum accumulator.
// Each rising edge of the asynchronous Go key adds the BCD digit on D.
// The sum wraps modulo 100, and a sticky flag records decimal overflow.
// A non-BCD digit parks the block in ERROR until Clr or reset.
module bcd_digit_accumulator #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  bcd_digit_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   go_s;
  logic                   go_d_r;
  logic                   pulse_s;
  logic [3:0]             tens_r;
  logic [3:0]             ones_r;
  logic                   ovf_r;
  logic                   err_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [8:0]             add_s;

  // One BCD digit is added into a two-digit BCD value.
  // The result is packed as {wrap, tens, ones}.
  // wrap is set when the tens digit rolls past 9.
  function automatic logic [8:0] bcd_add(
    input logic [3:0] tens,
    input logic [3:0] ones,
    input logic [3:0] digit
  );
    logic [4:0] t;
    logic [4:0] u;
    logic       carry;
    logic [3:0] o;
    logic [3:0] tn;
    logic       wrap;
    t = {1'b0, ones} + {1'b0, digit};
    if (t > 5'd9) begin
      o     = 4'(t - 5'd10);
      carry = 1'b1;
    end else begin
      o     = t[3:0];
      carry = 1'b0;
    end
    u = {1'b0, tens} + {4'd0, carry};
    if (u == 5'd10) begin
      tn   = 4'd0;
      wrap = 1'b1;
    end else begin
      tn   = u[3:0];
      wrap = 1'b0;
    end
    return {wrap, tn, o};
  endfunction

  assign go_s    = sync_r[SYNC_STAGES-1];
  assign pulse_s = go_s & ~go_d_r;

  // Synchronise the Go key and keep a delayed copy for rising-edge detection.
  // This chain keeps running through Clr.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      go_d_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.Go};
      go_d_r <= go_s;
    end
  end

  // Compute the candidate BCD sum from the digit present at the commit edge.
  always_comb begin
    add_s = 9'd0;
    add_s = bcd_add(tens_r, ones_r, bus.D);
  end

  // Decide the next FSM state from the edge pulse and the digit range check.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pulse_s) begin
          if (bus.D > 4'd9) begin
            state_next_s = ST_ERROR;
          end else begin
            state_next_s = ST_ADD;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADD:   state_next_s = ST_IDLE;
      ST_ERROR: state_next_s = ST_ERROR;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Hold the state register, the sum, flags and counter.
  // Clr wins over any add that commits or starts on the same edge.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
      tens_r  <= 4'd0;
      ones_r  <= 4'd0;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (bus.Clr) begin
      state_r <= ST_IDLE;
      tens_r  <= 4'd0;
      ones_r  <= 4'd0;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      err_r   <= (state_next_s == ST_ERROR);
      if (state_r == ST_ADD) begin
        ones_r <= add_s[3:0];
        tens_r <= add_s[7:4];
        ovf_r  <= ovf_r | add_s[8];
        if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        ones_r <= ones_r;
        tens_r <= tens_r;
        ovf_r  <= ovf_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  assign bus.Tens = tens_r;
  assign bus.Ones = ones_r;
  assign bus.Ovf  = ovf_r;
  assign bus.Err  = err_r;
  assign bus.Cnt  = cnt_r;
  assign bus.Busy = (state_r == ST_ADD);

endmodule
